// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the NPC memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam int TIMEOUT_DEF = 255;
  // Wide enough for the largest legal TIMEOUT (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU for the shared memory port.
// Latency: combinational grant; optional last_grant register updates on the granting edge.
// Backpressure: grants only while en is high (arbiter idle); at most one grant per cycle.
// Ports: en (arbiter idle), ifu_valid/lsu_valid (requests), ifu_gnt/lsu_gnt (one-hot grant);
//        clk/rst_n exist only when MEM_ARB_RR_EN is defined.
// Build option: MEM_ARB_RR_EN selects round-robin; otherwise fixed LSU-over-IFU priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic en,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic ifu_gnt,
  output logic lsu_gnt
);

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;
  logic   lsu_first;

  // On a conflict the requester that did not win last time goes first.
  assign lsu_first = (last_grant == OWN_IFU);
  assign lsu_gnt   = en && lsu_valid && (!ifu_valid || lsu_first);
  assign ifu_gnt   = en && ifu_valid && (!lsu_valid || !lsu_first);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_IFU;
    end else if (lsu_gnt) begin
      last_grant <= OWN_LSU;
    end else if (ifu_gnt) begin
      last_grant <= OWN_IFU;
    end
  end
`else
  assign lsu_gnt = en && lsu_valid;
  assign ifu_gnt = en && ifu_valid && !lsu_valid;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IFU fetches and LSU loads/stores, one access in flight.
// Latency: grant at T, mem_req_valid at T+1, response passed through combinationally (min 2 cycles).
// Backpressure: requesters stall on *_req_ready while busy; mem_req_ready stalls REQ; watchdog ends hung accesses.
// Ports: ifu_* / lsu_* requester handshakes and responses, mem_* registered request to memory and
//        response from memory, busy = state != IDLE.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (default fixed LSU priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  owner_t            owner;
  logic [CNT_W-1:0]  cnt;
  logic              ifu_gnt;
  logic              lsu_gnt;
  logic              resp_ok;
  logic              timeout;
  logic              resp_fire;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .en        (state == IDLE),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .ifu_gnt   (ifu_gnt),
    .lsu_gnt   (lsu_gnt)
  );

  assign ifu_req_ready = ifu_gnt;
  assign lsu_req_ready = lsu_gnt;

  // Responses only count in RESP; stray strobes in IDLE/REQ are dropped.
  // A real response in the watchdog's last cycle wins over the error.
  assign resp_ok   = (state == RESP) && mem_resp_valid;
  assign timeout   = (state != IDLE) && (cnt == CNT_LAST) && !resp_ok;
  assign resp_fire = resp_ok || timeout;

  // Drop the request once the watchdog fires so memory cannot accept an abandoned access.
  assign mem_req_valid = (state == REQ) && !timeout;
  assign busy          = (state != IDLE);

  assign ifu_resp_valid = resp_fire && (owner == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (owner == OWN_LSU);
  assign ifu_resp_err   = ifu_resp_valid && !resp_ok;
  assign lsu_resp_err   = lsu_resp_valid && !resp_ok;
  assign ifu_rdata      = (ifu_resp_valid && resp_ok) ? mem_rdata : '0;
  assign lsu_rdata      = (lsu_resp_valid && resp_ok) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IFU;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_gnt) begin
            owner     <= OWN_LSU;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
            cnt       <= '0;
            state     <= REQ;
          end else if (ifu_gnt) begin
            // Fetches are always plain reads.
            owner     <= OWN_IFU;
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (mem_req_ready) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_fire) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with TIMEOUT = 8.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rdy_wait;
    int          rsp_wait;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-requester transaction with optional accept/response waits.
  task automatic run_txn(input vec_t v);
    lsu_addr  = v.addr;
    lsu_wen   = v.wen;
    lsu_wdata = v.wdata;
    lsu_wmask = v.wmask;
    ifu_addr  = v.addr;
    if (v.is_lsu) lsu_req_valid = 1'b1;
    else          ifu_req_valid = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("grant_lsu_rdy", lsu_req_ready, v.is_lsu);
    chk("grant_ifu_rdy", ifu_req_ready, !v.is_lsu);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    // Scramble requester inputs: the memory side must hold the latched copy.
    lsu_addr  = '1;
    ifu_addr  = '1;
    lsu_wdata = 32'h5a5a5a5a;
    lsu_wmask = 4'h0;
    for (int w = 0; w <= v.rdy_wait; w++) begin
      mem_req_ready = (w == v.rdy_wait);
      @(negedge clk);
      chk("req_valid", mem_req_valid, 1);
      chk("req_busy", busy, 1);
      chk("req_addr", mem_addr, v.addr);
      chk("req_wen", mem_wen, v.exp_wen);
      chk("req_wmask", mem_wmask, v.exp_wmask);
      if (v.is_lsu) chk("req_wdata", mem_wdata, v.wdata);
      chk("req_no_resp", ifu_resp_valid | lsu_resp_valid, 0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    for (int w = 0; w <= v.rsp_wait; w++) begin
      mem_resp_valid = (w == v.rsp_wait);
      mem_rdata      = v.rdata;
      @(negedge clk);
      chk("resp_req_valid", mem_req_valid, 0);
      chk("resp_ifu_vld", ifu_resp_valid, (w == v.rsp_wait) && !v.is_lsu);
      chk("resp_lsu_vld", lsu_resp_valid, (w == v.rsp_wait) && v.is_lsu);
      chk("resp_ifu_rdata", ifu_rdata, ((w == v.rsp_wait) && !v.is_lsu) ? v.exp_rdata : 32'h0);
      chk("resp_lsu_rdata", lsu_rdata, ((w == v.rsp_wait) && v.is_lsu) ? v.exp_rdata : 32'h0);
      chk("resp_err", ifu_resp_err | lsu_resp_err, 0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic grant_cycle(input logic exp_lsu);
    @(negedge clk);
    chk("conf_lsu_rdy", lsu_req_ready, exp_lsu);
    chk("conf_ifu_rdy", ifu_req_ready, !exp_lsu);
    @(posedge clk); #1;
  endtask

  // Zero-wait memory service of the access granted on the previous edge.
  task automatic serve_zero(input logic own_lsu, input logic [31:0] addr, input logic wen,
                            input logic [3:0] wmask, input logic [31:0] wdata,
                            input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("sv_req_valid", mem_req_valid, 1);
    chk("sv_addr", mem_addr, addr);
    chk("sv_wen", mem_wen, wen);
    chk("sv_wmask", mem_wmask, wmask);
    if (own_lsu) chk("sv_wdata", mem_wdata, wdata);
    chk("sv_busy_rdy", ifu_req_ready | lsu_req_ready, 0);
    @(posedge clk); #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    @(negedge clk);
    chk("sv_lsu_vld", lsu_resp_valid, own_lsu);
    chk("sv_ifu_vld", ifu_resp_valid, !own_lsu);
    chk("sv_rdata", own_lsu ? lsu_rdata : ifu_rdata, rdata);
    chk("sv_other_rdata", own_lsu ? ifu_rdata : lsu_rdata, 0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    logic w;
    vecs[0] = '{1'b0, 32'h80000000, 1'b0, 32'h0,        4'h0, 0, 0, 32'h00100093, 1'b0, 4'h0, 32'h00100093};
    vecs[1] = '{1'b1, 32'h80000100, 1'b0, 32'h0,        4'hf, 1, 0, 32'h11223344, 1'b0, 4'hf, 32'h11223344};
    vecs[2] = '{1'b1, 32'h80001000, 1'b1, 32'hdeadbeef, 4'h1, 3, 2, 32'hcafef00d, 1'b1, 4'h1, 32'hcafef00d};
    vecs[3] = '{1'b0, 32'h80000008, 1'b1, 32'hffffffff, 4'hf, 0, 4, 32'ha5a5a5a5, 1'b0, 4'h0, 32'ha5a5a5a5};
    // Response lands when the watchdog counter is at TIMEOUT-1: must be a normal response.
    vecs[4] = '{1'b1, 32'h80000203, 1'b1, 32'h000000ab, 4'h8, 3, 3, 32'h0badf00d, 1'b1, 4'h8, 32'h0badf00d};
    vecs[5] = '{1'b0, 32'h80000020, 1'b0, 32'h0,        4'h0, 0, 6, 32'h13579bdf, 1'b0, 4'h0, 32'h13579bdf};

    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ready", ifu_req_ready | lsu_req_ready, 0);
    chk("rst_resp", ifu_resp_valid | lsu_resp_valid | ifu_resp_err | lsu_resp_err, 0);
    chk("rst_rdata", ifu_rdata | lsu_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Simultaneous requests, twice in a row.
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
    lsu_wdata = 32'hdeadbeef; lsu_wmask = 4'h1;
    grant_cycle(1'b1);
    lsu_req_valid = 1'b0;
    serve_zero(1'b1, 32'h80001000, 1'b1, 4'h1, 32'hdeadbeef, 32'h12345678);
    lsu_req_valid = 1'b1;
`ifdef MEM_ARB_RR_EN
    w = 1'b0;
`else
    w = 1'b1;
`endif
    grant_cycle(w);
    if (w) lsu_req_valid = 1'b0;
    else   ifu_req_valid = 1'b0;
    if (w) serve_zero(1'b1, 32'h80001000, 1'b1, 4'h1, 32'hdeadbeef, 32'h0000beef);
    else   serve_zero(1'b0, 32'h80000004, 1'b0, 4'h0, 32'h0, 32'h00000413);
    grant_cycle(!w);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    if (!w) serve_zero(1'b1, 32'h80001000, 1'b1, 4'h1, 32'hdeadbeef, 32'h0000beef);
    else    serve_zero(1'b0, 32'h80000004, 1'b0, 4'h0, 32'h0, 32'h00000413);

    // Watchdog: request accepted, memory never answers.
    lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b0; lsu_wmask = 4'hf;
    grant_cycle(1'b1);
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rdata     = 32'hffffffff;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_lsu_vld", lsu_resp_valid, i == 7);
      chk("to_lsu_err", lsu_resp_err, i == 7);
      chk("to_lsu_rdata", lsu_rdata, 0);
      chk("to_ifu_vld", ifu_resp_valid, 0);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
    end
    @(negedge clk);
    chk("to_idle_busy", busy, 0);
    mem_resp_valid = 1'b1;
    #1;
    chk("stray_lsu_vld", lsu_resp_valid, 0);
    chk("stray_ifu_vld", ifu_resp_valid, 0);
    chk("stray_rdata", lsu_rdata | ifu_rdata, 0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    chk("stray_busy", busy, 0);

    // Reset while in RESP abandons the access.
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000010;
    grant_cycle(1'b0);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_req_valid", mem_req_valid, 0);
    chk("arst_mem_addr", mem_addr, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h77777777;
    #1;
    chk("arst_ifu_vld", ifu_resp_valid, 0);
    chk("arst_rdata", ifu_rdata, 0);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
